trilat_select: RTL and testbench
================================

# trilat_select

Downstream stage of the two-circle `intersections` block. It takes the two candidate points {x1D,y1D,x2D,y2D} plus a third anchor circle {xA,yA,rA} and picks the candidate whose squared distance to the anchor best matches rA². The output is the trilaterated position.
- Sequential: one shared signed multiplier, an FSM, and a valid/ready handshake on both sides.
- Feeds the position consumer.

## Interface
- `N`, 8, coordinate width. Coordinates are signed N bits; radii are signed N+1 bits, same packing as `intersections`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cand`  in  4N  {x1D,y1D,x2D,y2D}, MSB first, signed N each. Matches the `o` output of `intersections`.
- `anchor`  in  3N+1  {xA[N], yA[N], rA[N+1]}, MSB first.
- `in_valid`  in  1  cand/anchor valid.
- `in_ready`  out  1  block can accept.
- `pos`  out  2N  {xD,yD} selected point.
- `sel`  out  1  0 = candidate 1, 1 = candidate 2.
- `err`  out  2N+3  unsigned |d² − rA²| of the selected point.
- `out_valid`  out  1  pos/sel/err valid.
- `out_ready`  in  1  consumer accepts.

## Operation
- States: IDLE, MUL, CMP, OUT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: register cand and anchor, clear the 3-bit step counter `k`, go to MUL.
- **MUL** (one product per cycle, k=0..4, signed (N+1)×(N+1)):
  - Operands:
    - k=0: rA·rA
    - k=1: dx1·dx1
    - k=2: dy1·dy1
    - k=3: dx2·dx2
    - k=4: dy2·dy2
  - dxi = xi − xA and dyi = yi − yA, each sign-extended to N+1 bits, never truncated.
  - Products are stored at 2N+2 bits.
  - At k=4, go to CMP.
- **CMP** (one cycle):
  - di² = dxi² + dyi², at 2N+3 bits.
  - erri = |di² − rA²|, computed at 2N+4 bits signed, then stored as 2N+3 unsigned.
  - sel = (err2 < err1). Ties go to candidate 1 (sel=0).
  - Latch pos, sel, err. Go to OUT.
- **OUT**
  - `out_valid`=1. pos/sel/err are held stable until `out_ready`.
  - On `out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE. There is no input skid and no overlap.
- rA is treated as signed; a negative rA squares like a positive one.
- No saturation is needed: all intermediate widths are exact for any input.

## Timing
- Reset values:
  - state IDLE, so `in_ready`=1.
  - `out_valid`=0, `pos`=0, `sel`=0, `err`=0, k=0.
- Latency: `out_valid` rises exactly 7 rising edges after the accepting edge, counting that edge (1 accept, 5 MUL, 1 CMP).
- Handshakes:
  - Input transfer: `in_valid`&&`in_ready` on a rising edge.
  - Output transfer: `out_valid`&&`out_ready` on a rising edge.
  - `in_ready` reasserts the cycle after the output transfer, never in the same cycle.
- Throughput: 1 result per 8 cycles when `out_ready` is held at 1.
- Input changes while not in IDLE are ignored, because operands are registered.
- `rst_n` low in any state aborts immediately and asynchronously to the reset values. The partial result is discarded and nothing is emitted.
- `out_ready` asserted outside OUT has no effect.

## Structure
- Shared package `trilat_pkg`:
  - width constants COORD_W=N, RAD_W=N+1, SQ_W=2N+2, ERR_W=2N+3;
  - state enum {IDLE, MUL, CMP, OUT};
  - field offsets for unpacking `cand` and `anchor`.
- One sub-module: the existing `MULT_` with N=M=N+1 as the shared multiplier.
- Operand selection is a mux on k.
- Difference subtracts use `SUB_` with N=M=N.

## Test plan
All cases use N=8.
- **Candidate 1 wins.**
  - Stimulus: cand=(3,4),(−3,−4); anchor=(6,8), r=5.
  - Response: sel=0, pos=(3,4), err=0, `out_valid` 7 edges after accept.
- **Candidate 2 wins (order swapped).**
  - Stimulus: cand=(−3,−4),(3,4), same anchor.
  - Response: sel=1, pos=(3,4), err=0. Also check candidate 1's err: 200.
- **Tie.**
  - Stimulus: cand=(0,5),(5,0); anchor=(0,0), r=5.
  - Response: both errors 0, sel=0, pos=(0,5).
- **Extremes.**
  - Stimulus: cand=(−128,−128),(0,0); anchor=(127,127), r=255.
  - Response: d1²=130050, rA²=65025, err1=65025; d2²=32258, err2=32767; so sel=1, pos=(0,0), err=32767, with no overflow.
- **Backpressure.**
  - Stimulus: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - Response: pos/sel/err stable, `in_ready`=0, a new `in_valid` is ignored. Release `out_ready`; `in_ready`=1 on the next cycle.
- **Reset mid-operation.**
  - Stimulus: assert `rst_n`=0 while k=2.
  - Response: outputs immediately at reset values, `in_ready`=1 after release, no stale `out_valid`. A following transaction produces the correct result.

Source files
------------

// File: rtl/trilat_pkg.sv
// Shared widths, field offsets, FSM encodings and payload types for trilat_select.
package trilat_pkg;

  localparam int unsigned COORD_W = 8;
  localparam int unsigned RAD_W   = COORD_W + 1;
  localparam int unsigned SQ_W    = 2 * COORD_W + 2;
  localparam int unsigned ERR_W   = 2 * COORD_W + 3;
  localparam int unsigned DIFF_W  = ERR_W + 1;
  localparam int unsigned CAND_W  = 4 * COORD_W;
  localparam int unsigned ANCH_W  = 3 * COORD_W + 1;
  localparam int unsigned POS_W   = 2 * COORD_W;
  localparam int unsigned K_W     = 3;

  // Bit offsets of each field inside the packed cand / anchor buses
  localparam int unsigned X1_LSB = 3 * COORD_W;
  localparam int unsigned Y1_LSB = 2 * COORD_W;
  localparam int unsigned X2_LSB = COORD_W;
  localparam int unsigned Y2_LSB = 0;
  localparam int unsigned XA_LSB = COORD_W + RAD_W;
  localparam int unsigned YA_LSB = RAD_W;
  localparam int unsigned RA_LSB = 0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] CMP  = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
  } cand_t;

  typedef struct packed {
    logic [COORD_W-1:0] xa;
    logic [COORD_W-1:0] ya;
    logic [RAD_W-1:0]   ra;
  } anchor_t;

  // |d2 - r2| with both squares non-negative; the signed difference is one bit wider
  function automatic logic [ERR_W-1:0] abs_err(input logic [ERR_W-1:0] d2,
                                              input logic [SQ_W-1:0]  r2);
    logic signed [DIFF_W-1:0] diff;
    diff = $signed({1'b0, d2}) - $signed({2'b00, r2});
    return diff[DIFF_W-1] ? ERR_W'(-diff) : ERR_W'(diff);
  endfunction

endpackage

// File: rtl/MULT_.sv
// Signed full-precision multiplier, product width N+M.
module MULT_ #(
  parameter int unsigned N = 9,
  parameter int unsigned M = 9
) (
  input  logic signed [N-1:0]   a,
  input  logic signed [M-1:0]   b,
  output logic signed [N+M-1:0] p
);

  logic signed [N+M-1:0] a_ext;
  logic signed [N+M-1:0] b_ext;

  assign a_ext = {{M{a[N-1]}}, a};
  assign b_ext = {{N{b[M-1]}}, b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/SUB_.sv
// Signed subtractor a - b, result one bit wider than the wider operand so it never wraps.
module SUB_ #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 8
) (
  input  logic signed [N-1:0]                  a,
  input  logic signed [M-1:0]                  b,
  output logic signed [((N > M) ? N : M):0]    d
);

  localparam int unsigned W = ((N > M) ? N : M) + 1;

  logic signed [W-1:0] a_ext;
  logic signed [W-1:0] b_ext;

  assign a_ext = {{(W-N){a[N-1]}}, a};
  assign b_ext = {{(W-M){b[M-1]}}, b};
  assign d     = a_ext - b_ext;

endmodule

// File: rtl/trilat_select.sv
// Picks the intersection candidate whose squared distance to a third anchor best matches rA^2,
// sequencing five squares through one shared multiplier.
module trilat_select
  import trilat_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CAND_W-1:0] cand,
  input  logic [ANCH_W-1:0] anchor,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [POS_W-1:0]  pos,
  output logic              sel,
  output logic [ERR_W-1:0]  err,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [1:0]     state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic           load_c;

  cand_t   cand_q;
  anchor_t anch_q;

  logic signed [RAD_W-1:0] dx1, dy1, dx2, dy2;
  logic signed [RAD_W-1:0] op_c;
  logic signed [SQ_W-1:0]  prod_c;

  logic [SQ_W-1:0]  rsq_q, dx1sq_q, dy1sq_q, dx2sq_q, dy2sq_q;
  logic [ERR_W-1:0] d1_c, d2_c, err1_c, err2_c;
  logic             sel_c;

  SUB_ #(.N(COORD_W), .M(COORD_W)) u_sub_dx1 (.a(cand_q.x1), .b(anch_q.xa), .d(dx1));
  SUB_ #(.N(COORD_W), .M(COORD_W)) u_sub_dy1 (.a(cand_q.y1), .b(anch_q.ya), .d(dy1));
  SUB_ #(.N(COORD_W), .M(COORD_W)) u_sub_dx2 (.a(cand_q.x2), .b(anch_q.xa), .d(dx2));
  SUB_ #(.N(COORD_W), .M(COORD_W)) u_sub_dy2 (.a(cand_q.y2), .b(anch_q.ya), .d(dy2));

  // Every product is a square, so both multiplier ports take the same operand
  always_comb begin
    case (k_q)
      3'd1:    op_c = dx1;
      3'd2:    op_c = dy1;
      3'd3:    op_c = dx2;
      3'd4:    op_c = dy2;
      default: op_c = anch_q.ra;
    endcase
  end

  MULT_ #(.N(RAD_W), .M(RAD_W)) u_mult (.a(op_c), .b(op_c), .p(prod_c));

  assign d1_c   = ERR_W'(dx1sq_q) + ERR_W'(dy1sq_q);
  assign d2_c   = ERR_W'(dx2sq_q) + ERR_W'(dy2sq_q);
  assign err1_c = abs_err(d1_c, rsq_q);
  assign err2_c = abs_err(d2_c, rsq_q);
  assign sel_c  = (err2_c < err1_c);

  // Next-state and step counter
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_c  = 1'b1;
          k_d     = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (k_q == 3'd4) begin
          k_d     = '0;
          state_d = CMP;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      CMP:     state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == OUT);
    end
  end

  // Operand capture, product storage and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q  <= '0;
      anch_q  <= '0;
      rsq_q   <= '0;
      dx1sq_q <= '0;
      dy1sq_q <= '0;
      dx2sq_q <= '0;
      dy2sq_q <= '0;
      pos     <= '0;
      sel     <= 1'b0;
      err     <= '0;
    end else begin
      if (load_c) begin
        cand_q.x1 <= cand[X1_LSB +: COORD_W];
        cand_q.y1 <= cand[Y1_LSB +: COORD_W];
        cand_q.x2 <= cand[X2_LSB +: COORD_W];
        cand_q.y2 <= cand[Y2_LSB +: COORD_W];
        anch_q.xa <= anchor[XA_LSB +: COORD_W];
        anch_q.ya <= anchor[YA_LSB +: COORD_W];
        anch_q.ra <= anchor[RA_LSB +: RAD_W];
      end
      if (state_q == MUL) begin
        case (k_q)
          3'd0:    rsq_q   <= prod_c;
          3'd1:    dx1sq_q <= prod_c;
          3'd2:    dy1sq_q <= prod_c;
          3'd3:    dx2sq_q <= prod_c;
          default: dy2sq_q <= prod_c;
        endcase
      end
      if (state_q == CMP) begin
        pos <= sel_c ? {cand_q.x2, cand_q.y2} : {cand_q.x1, cand_q.y1};
        sel <= sel_c;
        err <= sel_c ? err2_c : err1_c;
      end
    end
  end

endmodule

// File: tb/tb_trilat_select.sv
// Directed bench for trilat_select: hand-computed results, latency, backpressure and mid-run reset.
module tb_trilat_select;

  logic        clk;
  logic        rst_n;
  logic [31:0] cand;
  logic [24:0] anchor;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pos;
  logic        sel;
  logic [18:0] err;
  logic        out_valid;
  logic        out_ready;

  int passed = 0;
  int total  = 0;
  int lat;
  bit seen;

  trilat_select dut (
    .clk(clk), .rst_n(rst_n), .cand(cand), .anchor(anchor),
    .in_valid(in_valid), .in_ready(in_ready), .pos(pos), .sel(sel),
    .err(err), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_cand(int x1, int y1, int x2, int y2);
    return {8'(x1), 8'(y1), 8'(x2), 8'(y2)};
  endfunction

  function automatic logic [24:0] mk_anch(int xa, int ya, int r);
    return {8'(xa), 8'(ya), 9'(r)};
  endfunction

  function automatic logic [15:0] mk_pos(int x, int y);
    return {8'(x), 8'(y)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Present one transaction, accept it, and measure edges until out_valid
  task automatic start_txn(input string tag, input logic [31:0] c, input logic [24:0] a);
    @(negedge clk);
    cand     = c;
    anchor   = a;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd7);
  endtask

  task automatic finish_txn(input string tag, input logic [15:0] ep, input logic es,
                            input logic [18:0] ee);
    chk({tag, "_pos"}, 32'(pos), 32'(ep));
    chk({tag, "_sel"}, 32'(sel), 32'(es));
    chk({tag, "_err"}, 32'(err), 32'(ee));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cand      = '0;
    anchor    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pos",       32'(pos),       32'd0);
    chk("rst_sel",       32'(sel),       32'd0);
    chk("rst_err",       32'(err),       32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Candidate 1 exact; candidate 2 has d2=225, err 200
    start_txn("c1win", mk_cand(3, 4, -3, -4), mk_anch(6, 8, 5));
    finish_txn("c1win", mk_pos(3, 4), 1'b0, 19'd0);

    start_txn("c2win", mk_cand(-3, -4, 3, 4), mk_anch(6, 8, 5));
    finish_txn("c2win", mk_pos(3, 4), 1'b1, 19'd0);

    // Both candidates at (-3,-4) expose candidate 1's error of 200
    start_txn("err200", mk_cand(-3, -4, -3, -4), mk_anch(6, 8, 5));
    finish_txn("err200", mk_pos(-3, -4), 1'b0, 19'd200);

    start_txn("tie", mk_cand(0, 5, 5, 0), mk_anch(0, 0, 5));
    finish_txn("tie", mk_pos(0, 5), 1'b0, 19'd0);

    // d1=130050, d2=32258, r2=65025 -> err1=65025, err2=32767
    start_txn("extreme", mk_cand(-128, -128, 0, 0), mk_anch(127, 127, 255));
    finish_txn("extreme", mk_pos(0, 0), 1'b1, 19'd32767);

    start_txn("neg_r", mk_cand(3, 4, -3, -4), mk_anch(6, 8, -5));
    finish_txn("neg_r", mk_pos(3, 4), 1'b0, 19'd0);

    // Backpressure: results held, no acceptance, foreign input ignored
    start_txn("bp", mk_cand(-3, -4, 3, 4), mk_anch(6, 8, 5));
    cand     = mk_cand(0, 5, 5, 0);
    anchor   = mk_anch(0, 0, 5);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(in_ready),  32'd0);
      chk("bp_hold_pos",   32'(pos),       32'(mk_pos(3, 4)));
      chk("bp_hold_err",   32'(err),       32'd0);
    end
    in_valid = 1'b0;
    finish_txn("bp", mk_pos(3, 4), 1'b1, 19'd0);

    // Reset while k=2 (two MUL edges after accept)
    @(negedge clk);
    cand     = mk_cand(-128, -128, 0, 0);
    anchor   = mk_anch(127, 127, 255);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_pos",   32'(pos),       32'd0);
    chk("mid_rst_err",   32'(err),       32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_stale", 32'(seen), 32'd0);
    chk("mid_rst_idle",     32'(in_ready), 32'd1);

    start_txn("post_rst", mk_cand(-128, -128, 0, 0), mk_anch(127, 127, 255));
    finish_txn("post_rst", mk_pos(0, 0), 1'b1, 19'd32767);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
